// File: rtl/i2c_codec_init_seq.sv
// WM8731 power-up sequencer: walks an 11-entry register table through the 24-bit
// I2C write engine, one transfer per entry, with NACK retries and a per-state watchdog.
`timescale 1ns/1ps

module i2c_codec_init_seq #(
    parameter logic [7:0] DEV_ADDR   = 8'h34,
    parameter int         MAX_TRIES  = 3,
    parameter int         GAP_CYCLES = 16,
    parameter int         TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iStart,
    input  logic        iReady,
    input  logic        iNACK,
    output logic        oGO,
    output logic [23:0] oDATA,
    output logic        oBusy,
    output logic        oDone,
    output logic        oError,
    output logic [3:0]  oIndex
);

    localparam logic [3:0] LAST_IDX = 4'd10;
    localparam int CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TRY_W   = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_DONE, S_CHECK, S_GAP, S_DONE, S_ERROR
    } state_e;

    // Codec register image {reg[6:0], data[8:0]}; the activate write must stay last.
    function automatic logic [15:0] table_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    return 16'h1E00;
            4'd1:    return 16'h0C00;
            4'd2:    return 16'h0097;
            4'd3:    return 16'h0297;
            4'd4:    return 16'h0479;
            4'd5:    return 16'h0679;
            4'd6:    return 16'h0812;
            4'd7:    return 16'h0A00;
            4'd8:    return 16'h0E42;
            4'd9:    return 16'h1000;
            4'd10:   return 16'h1201;
            default: return 16'h0000;
        endcase
    endfunction

    state_e           state_q, state_d;
    logic [3:0]       index_q, index_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [23:0]      data_q,  data_d;
    logic             start_q;

    logic start_edge, wd_expired, gap_done, retry_ok;

    assign start_edge = iStart & ~start_q;
    assign wd_expired = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign gap_done   = (cnt_q == CNT_W'(GAP_CYCLES - 1));
    assign retry_ok   = (int'(tries_q) + 1) < MAX_TRIES;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            index_q <= '0;
            tries_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            state_q <= state_d;
            index_q <= index_d;
            tries_q <= tries_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            start_q <= iStart;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        state_d = state_q;
        index_d = index_q;
        tries_d = tries_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_edge) begin
                    state_d = S_ISSUE;
                    index_d = '0;
                    tries_d = '0;
                end
            end
            S_ISSUE: begin
                if (!iReady)         state_d = S_WAIT_DONE;
                else if (wd_expired) state_d = S_ERROR;
            end
            S_WAIT_DONE: begin
                if (iReady)          state_d = S_CHECK;
                else if (wd_expired) state_d = S_ERROR;
            end
            S_CHECK: begin
                if (!iNACK) begin
                    if (index_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        index_d = index_q + 4'd1;
                        tries_d = '0;
                        state_d = S_GAP;
                    end
                end else if (retry_ok) begin
                    tries_d = tries_q + 1'b1;
                    state_d = S_GAP;
                end else begin
                    state_d = S_ERROR;
                end
            end
            S_GAP: begin
                if (gap_done) state_d = S_ISSUE;
            end
            default: state_d = S_IDLE;
        endcase

        // Counter restarts on every state entry and only runs where something is timed.
        if (state_d != state_q)
            cnt_d = '0;
        else if (state_q inside {S_ISSUE, S_WAIT_DONE, S_GAP})
            cnt_d = cnt_q + 1'b1;
        else
            cnt_d = '0;

        // Payload is latched once on ISSUE entry and held until the next one.
        if (state_d == S_ISSUE && state_q != S_ISSUE)
            data_d = {DEV_ADDR, table_entry(index_d)};
        else
            data_d = data_q;
    end

    always_comb begin
        oGO    = (state_q == S_ISSUE);
        oBusy  = state_q inside {S_ISSUE, S_WAIT_DONE, S_CHECK, S_GAP};
        oDone  = (state_q == S_DONE);
        oError = (state_q == S_ERROR);
        oDATA  = data_q;
        oIndex = index_q;
    end

endmodule
